// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {remainder, dividend} left, subtract divisor, select.
module div_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] dvd_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] dvd_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             q_bit;

    // One extra bit beyond the remainder keeps the borrow as an explicit sign.
    assign shifted = {rem_in, dvd_in[WIDTH-1]};
    assign diff    = shifted - (WIDTH+2)'(divisor);
    assign q_bit   = ~diff[WIDTH+1];
    assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    // Quotient bits fill the dividend register from the LSB as its bits are consumed.
    assign dvd_out = {dvd_in[WIDTH-2:0], q_bit};

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Optional macro SEQ_DIVIDER_DBZ_FAST_EN: divide-by-zero short-circuits to DONE with dbz set.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int unsigned        CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_nxt;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvd_step;
    logic [WIDTH-1:0] dsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             last_iter;
    logic             fast_dbz;

`ifdef SEQ_DIVIDER_DBZ_FAST_EN
    assign fast_dbz = (divisor == '0);
`else
    assign fast_dbz = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_in  (dvd_q),
        .divisor (dsr_q),
        .rem_out (rem_step),
        .dvd_out (dvd_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = fast_dbz ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    last_iter = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = fast_dbz ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; visible results change only on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            busy <= (state_nxt == ST_RUN);
            done <= (state_nxt == ST_DONE);
            if (accept) begin
                rem_q <= '0;
                dvd_q <= dividend;
                dsr_q <= divisor;
                cnt_q <= '0;
                if (fast_dbz) begin
                    quotient  <= '1;
                    remainder <= dividend;
                    dbz       <= 1'b1;
                end
            end else if (state_q == ST_RUN) begin
                rem_q <= rem_step;
                dvd_q <= dvd_step;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_iter) begin
                    quotient  <= dvd_step;
                    remainder <= rem_step[WIDTH-1:0];
                    dbz       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin a division.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned numerator, sampled with start.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned denominator, sampled with start.
REQ-007 SHALL have port busy, output, 1 bit: division in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking quotient and remainder valid.
REQ-009 SHALL have port quotient, output, WIDTH bits: unsigned result.
REQ-010 SHALL have port remainder, output, WIDTH bits: unsigned remainder.
REQ-011 SHALL have port dbz, output, 1 bit: divide-by-zero flag, valid while done is high and held afterwards.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start on a rising edge only in IDLE or DONE, capture the operands, clear the iteration counter and enter RUN.
REQ-014 SHALL ignore start and any operand changes while in RUN.
REQ-015 SHALL use restoring division in RUN, one quotient bit per cycle, MSB first: shift {partial remainder, dividend} left by one, subtract divisor, keep the difference and set the quotient bit when the difference is non-negative, otherwise restore.
REQ-016 SHALL hold the partial remainder at WIDTH+1 bits so the subtraction borrow is the sign bit, with no truncation before the comparison.
REQ-017 SHALL leave RUN for DONE after exactly WIDTH RUN cycles, making done high in the (WIDTH+1)th cycle after the start edge.
REQ-018 SHALL hold done high for exactly one cycle, in DONE.
REQ-019 SHALL then return DONE to IDLE, or go straight to RUN if start is sampled in DONE (back-to-back operation).
REQ-020 SHALL drive busy high exactly when the state is RUN.
REQ-021 SHALL hold quotient, remainder and dbz stable from done until the next done.
REQ-022 SHALL not change the visible outputs during RUN, updating only internal registers.
REQ-023 SHALL, for divisor = 0 without the option in REQ-028, produce the natural restoring result: quotient all ones, remainder = dividend.
REQ-024 SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every divisor ≠ 0.

Reset
REQ-025 SHALL, while rst_n is low, immediately force: state IDLE, busy 0, done 0, quotient 0, remainder 0, dbz 0, counter 0.
REQ-026 SHALL abandon a division interrupted by reset mid-RUN, with no done pulse after reset release.
REQ-027 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL provide the macro SEQ_DIVIDER_DBZ_FAST_EN.
- Defined: divisor = 0 sampled with start skips RUN and goes directly to DONE; done pulses 1 cycle after the start edge with quotient all ones, remainder = dividend, dbz = 1.
- dbz SHALL be 0 for every nonzero divisor.
REQ-029 SHALL, with SEQ_DIVIDER_DBZ_FAST_EN undefined, tie dbz to 0 and treat divisor = 0 like any other operand: full WIDTH-cycle run with the REQ-023 result.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE/RUN/DONE) and the default WIDTH constant in the shared package seq_divider_pkg.
REQ-031 SHALL put one restoring iteration (shift, subtract, select) in the combinational sub-module div_step, instantiated once and reused each RUN cycle.

Verification
REQ-032 SHALL cover these directed scenarios (WIDTH = 4):
- 13 / 3: start for one cycle -> busy for 4 cycles, done in cycle 5, quotient = 4, remainder = 1, dbz = 0.
- 15 / 1, then 2 / 3 back-to-back (start during done) -> 15 r 0 first, then 0 r 2 exactly 5 cycles later, with no IDLE gap.
- 7 / 0 -> with macro: done at cycle 1, quotient = 15, remainder = 7, dbz = 1; without macro: done at cycle 5, quotient = 15, remainder = 7, dbz = 0.
- Start pulsed again in cycle 2 of 9 / 2 with operands changed to 1 / 1 -> ignored; result 4 r 1, a single done.
- rst_n low at cycle 2 of 12 / 5 -> all outputs 0 at once, no done after release; a fresh 12 / 5 gives 2 r 2.
- Exhaustive loop over all 256 dividend/divisor pairs -> every nonzero-divisor result equals dividend/divisor and dividend%divisor; waveforms dumped to VCD.
